// File: rtl/garage_ctrl_if.sv
// Sensor and status bundle between the beam sensors / display side and garage_ctrl.
// Parameter CNT_W must match the controller's count width.
interface garage_ctrl_if #(
    parameter int CNT_W = 4
);
    // Sensor levels are sampled on every clock; the tick outputs are single-cycle
    // strobes with no back-pressure, and count/full/empty/gate_open are levels.
    logic             sen_a;
    logic             sen_b;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             in_tick;
    logic             out_tick;
    logic             err_tick;
    logic             gate_open;

    modport master (
        output sen_a, sen_b,
        input  count, full, empty, in_tick, out_tick, err_tick, gate_open
    );

    modport slave (
        input  sen_a, sen_b,
        output count, full, empty, in_tick, out_tick, err_tick, gate_open
    );
endinterface

// File: rtl/garage_ctrl.sv
// Bidirectional garage occupancy controller: beam-pair passage decoder, saturating
// occupancy count and barrier hold timer. Optional macro GARAGE_SYNC_EN adds 2-flop sensor synchronizers.
module garage_ctrl #(
    parameter int CAPACITY  = 9,
    parameter int CNT_W     = 4,
    parameter int GATE_HOLD = 50000000,
    parameter int TMR_W     = 26
) (
    input  logic         clk,
    input  logic         reset,
    garage_ctrl_if.slave bus,
    output logic [2:0]   state_dbg
);
    typedef enum logic [2:0] {
        IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, WAIT_CLR
    } state_t;

    localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] HOLD_C = TMR_W'(GATE_HOLD);

    state_t           state_q;
    state_t           nxt;
    logic [CNT_W-1:0] count_q;
    logic [TMR_W-1:0] timer_q;
    logic             held_q;
    logic             gate_q;
    logic             in_tick_q;
    logic             out_tick_q;
    logic             err_tick_q;
    logic             sa;
    logic             sb;
    logic [1:0]       s;
    logic             ev_in;
    logic             ev_out;
    logic             in_path;
    logic             leave_path;
    logic             open_req;
    logic             at_full;
    logic             at_empty;

`ifdef GARAGE_SYNC_EN
    logic [1:0] a_sync;
    logic [1:0] b_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sync <= 2'b00;
            b_sync <= 2'b00;
        end else begin
            a_sync <= {a_sync[0], bus.sen_a};
            b_sync <= {b_sync[0], bus.sen_b};
        end
    end

    assign sa = a_sync[1];
    assign sb = b_sync[1];
`else
    assign sa = bus.sen_a;
    assign sb = bus.sen_b;
`endif

    assign s        = {sa, sb};
    assign at_full  = (count_q == CAP_C);
    assign at_empty = (count_q == '0);

    // Passage decoder: unchanged pattern holds, neighbours step along or back the path.
    always_comb begin
        nxt    = state_q;
        ev_in  = 1'b0;
        ev_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (s == 2'b10)      nxt = IN1;
                else if (s == 2'b01) nxt = OUT1;
                else if (s == 2'b11) nxt = WAIT_CLR;
            end
            IN1: begin
                if (s == 2'b11)      nxt = IN2;
                else if (s == 2'b00) nxt = IDLE;
                else if (s == 2'b01) nxt = WAIT_CLR;
            end
            IN2: begin
                if (s == 2'b01)      nxt = IN3;
                else if (s == 2'b10) nxt = IN1;
                else if (s == 2'b00) nxt = WAIT_CLR;
            end
            IN3: begin
                if (s == 2'b00) begin
                    nxt   = IDLE;
                    ev_in = 1'b1;
                end else if (s == 2'b11) nxt = IN2;
                else if (s == 2'b10)     nxt = WAIT_CLR;
            end
            OUT1: begin
                if (s == 2'b11)      nxt = OUT2;
                else if (s == 2'b00) nxt = IDLE;
                else if (s == 2'b10) nxt = WAIT_CLR;
            end
            OUT2: begin
                if (s == 2'b10)      nxt = OUT3;
                else if (s == 2'b01) nxt = OUT1;
                else if (s == 2'b00) nxt = WAIT_CLR;
            end
            OUT3: begin
                if (s == 2'b00) begin
                    nxt    = IDLE;
                    ev_out = 1'b1;
                end else if (s == 2'b11) nxt = OUT2;
                else if (s == 2'b01)     nxt = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (s == 2'b00) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign in_path    = (state_q != IDLE) && (state_q != WAIT_CLR);
    assign leave_path = in_path && ((nxt == IDLE) || (nxt == WAIT_CLR));
    assign open_req   = (state_q == IDLE) &&
                        (((nxt == IN1) && !at_full) || ((nxt == OUT1) && !at_empty));

    // held_q: gate kept open by an active passage, timer frozen until the path ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            timer_q    <= '0;
            held_q     <= 1'b0;
            gate_q     <= 1'b0;
            in_tick_q  <= 1'b0;
            out_tick_q <= 1'b0;
            err_tick_q <= 1'b0;
        end else begin
            state_q    <= nxt;
            in_tick_q  <= 1'b0;
            out_tick_q <= 1'b0;
            err_tick_q <= 1'b0;

            if (ev_in) begin
                if (!at_full) begin
                    count_q   <= count_q + 1'b1;
                    in_tick_q <= 1'b1;
                end else begin
                    err_tick_q <= 1'b1;
                end
            end else if (ev_out) begin
                if (!at_empty) begin
                    count_q    <= count_q - 1'b1;
                    out_tick_q <= 1'b1;
                end else begin
                    err_tick_q <= 1'b1;
                end
            end

            if (open_req) begin
                gate_q  <= 1'b1;
                held_q  <= 1'b1;
                timer_q <= '0;
            end else if (leave_path && held_q) begin
                held_q  <= 1'b0;
                timer_q <= HOLD_C;
            end else if (gate_q && !held_q) begin
                if (timer_q == '0) gate_q  <= 1'b0;
                else               timer_q <= timer_q - 1'b1;
            end
        end
    end

    assign bus.count     = count_q;
    assign bus.full      = at_full;
    assign bus.empty     = at_empty;
    assign bus.in_tick   = in_tick_q;
    assign bus.out_tick  = out_tick_q;
    assign bus.err_tick  = err_tick_q;
    assign bus.gate_open = gate_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_garage_ctrl.sv
// Self-checking bench for garage_ctrl: directed scenarios plus random passages checked
// against a path-progress reference model. Build with GARAGE_SYNC_EN to cover the synchronizers.
module tb_garage_ctrl;
    localparam int CAPACITY  = 3;
    localparam int CNT_W     = 4;
    localparam int GATE_HOLD = 4;
    localparam int TMR_W     = 4;
`ifdef GARAGE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] state_dbg;

    garage_ctrl_if #(.CNT_W(CNT_W)) bus ();

    garage_ctrl #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W),
        .GATE_HOLD(GATE_HOLD),
        .TMR_W    (TMR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int              n_cmp = 0;
    int              n_bad = 0;
    int              n_in_seen = 0;
    int              n_out_seen = 0;
    int              n_err_seen = 0;
    logic [CNT_W-1:0] exp_q[$];
    logic [1:0]      pipe[$];
    int              m_dir;        // +1 entering, -1 leaving, 0 no passage in progress
    int              m_depth;      // how many beam patterns of the path have been reached
    bit              m_stuck;      // waiting for both beams clear after an illegal pattern
    int              m_cnt;
    bit              m_held;
    int              m_hold_left;  // cycles the gate still stays open after a passage
    bit              m_in, m_out, m_err;

    // Beam pattern at position k along a passage in direction d (k=0 is both clear).
    function automatic logic [1:0] pat(input int d, input int k);
        if (k == 0) return 2'b00;
        if (k == 2) return 2'b11;
        if (d > 0) return (k == 1) ? 2'b10 : 2'b01;
        return (k == 1) ? 2'b01 : 2'b10;
    endfunction

    task automatic model_reset();
        m_dir = 0; m_depth = 0; m_stuck = 0; m_cnt = 0;
        m_held = 0; m_hold_left = 0; m_in = 0; m_out = 0; m_err = 0;
        pipe.delete();
        exp_q.delete();
        for (int i = 0; i < SYNC_LAT; i++) pipe.push_back(2'b00);
    endtask

    task automatic model_step(input logic [1:0] s_in);
        logic [1:0] s;
        bit enter, leave, done;
        pipe.push_back(s_in);
        s = pipe.pop_front();
        enter = 0; leave = 0; done = 0;
        m_in = 0; m_out = 0; m_err = 0;
        if (m_stuck) begin
            if (s == 2'b00) m_stuck = 0;
        end else if (m_dir == 0) begin
            if (s == 2'b10)      begin m_dir = 1;  m_depth = 1; enter = 1; end
            else if (s == 2'b01) begin m_dir = -1; m_depth = 1; enter = 1; end
            else if (s == 2'b11) m_stuck = 1;
        end else if (s == pat(m_dir, m_depth)) begin
            // beams unchanged
        end else if (m_depth == 3 && s == 2'b00) begin
            done = 1; leave = 1;
        end else if (m_depth < 3 && s == pat(m_dir, m_depth + 1)) begin
            m_depth++;
        end else if (s == pat(m_dir, m_depth - 1)) begin
            m_depth--;
            if (m_depth == 0) leave = 1;
        end else begin
            m_stuck = 1; leave = 1;
        end

        if (done) begin
            if (m_dir > 0) begin
                if (m_cnt < CAPACITY) begin m_cnt++; m_in = 1; exp_q.push_back(CNT_W'(m_cnt)); end
                else m_err = 1;
            end else begin
                if (m_cnt > 0) begin m_cnt--; m_out = 1; exp_q.push_back(CNT_W'(m_cnt)); end
                else m_err = 1;
            end
        end

        if (enter && ((m_dir > 0) ? (m_cnt < CAPACITY) : (m_cnt > 0))) begin
            m_held = 1; m_hold_left = 0;
        end else if (leave && m_held) begin
            m_held = 0; m_hold_left = GATE_HOLD + 1;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
        end
        if (leave) begin m_dir = 0; m_depth = 0; end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [CNT_W-1:0] e;
        check("count", 32'(bus.count), 32'(m_cnt));
        check("gate_open", 32'(bus.gate_open), 32'(m_held || (m_hold_left > 0)));
        check("in_tick", 32'(bus.in_tick), 32'(m_in));
        check("out_tick", 32'(bus.out_tick), 32'(m_out));
        check("err_tick", 32'(bus.err_tick), 32'(m_err));
        check("full", 32'(bus.full), 32'(m_cnt == CAPACITY));
        check("empty", 32'(bus.empty), 32'(m_cnt == 0));
        if (bus.in_tick === 1'b1) n_in_seen++;
        if (bus.out_tick === 1'b1) n_out_seen++;
        if (bus.err_tick === 1'b1) n_err_seen++;
        if (bus.in_tick === 1'b1 || bus.out_tick === 1'b1) begin
            if (exp_q.size() == 0) check("tick_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                check("tick_count", 32'(bus.count), 32'(e));
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [1:0] s);
        bus.sen_a = s[1];
        bus.sen_b = s[0];
        @(posedge clk);
        model_step(s);
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [1:0] s, input int n);
        repeat (n) drive(s);
    endtask

    task automatic seq4(input logic [1:0] p0, input logic [1:0] p1,
                        input logic [1:0] p2, input logic [1:0] p3, input int h);
        hold(p0, h); hold(p1, h); hold(p2, h); hold(p3, h);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int in0, out0, err0, h, kind;
        logic [1:0] r;
        bus.sen_a = 1'b0;
        bus.sen_b = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_gate", 32'(bus.gate_open), 32'd0);
        check("rst_ticks", 32'({bus.in_tick, bus.out_tick, bus.err_tick}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        model_step(2'b00);
        #1;
        compare_all();

        // single entry, 3 cycles per pattern, then let the gate time out
        seq4(2'b10, 2'b11, 2'b01, 2'b00, 3);
        hold(2'b00, 8);
        check("s1_count", 32'(bus.count), 32'd1);
        check("s1_in_ticks", 32'(n_in_seen), 32'd1);
        check("s1_err_ticks", 32'(n_err_seen), 32'd0);
        check("s1_gate_closed", 32'(bus.gate_open), 32'd0);

        // fill to capacity, then one entry too many
        seq4(2'b10, 2'b11, 2'b01, 2'b00, 2);
        seq4(2'b10, 2'b11, 2'b01, 2'b00, 2);
        hold(2'b00, 8);
        err0 = n_err_seen;
        seq4(2'b10, 2'b11, 2'b01, 2'b00, 2);
        hold(2'b00, 3);
        check("full_err_once", 32'(n_err_seen - err0), 32'd1);
        check("full_count", 32'(bus.count), 32'd3);
        check("full_flag", 32'(bus.full), 32'd1);

        // exits down to empty, then one exit too many
        out0 = n_out_seen;
        repeat (3) begin
            seq4(2'b01, 2'b11, 2'b10, 2'b00, 2);
            hold(2'b00, 2);
        end
        check("exit_ticks", 32'(n_out_seen - out0), 32'd3);
        err0 = n_err_seen;
        seq4(2'b01, 2'b11, 2'b10, 2'b00, 2);
        hold(2'b00, 3);
        check("empty_err_once", 32'(n_err_seen - err0), 32'd1);
        check("empty_count", 32'(bus.count), 32'd0);
        check("empty_flag", 32'(bus.empty), 32'd1);

        // back-out and illegal direct 11: no ticks at all
        in0 = n_in_seen; out0 = n_out_seen; err0 = n_err_seen;
        seq4(2'b10, 2'b11, 2'b10, 2'b00, 2);
        hold(2'b11, 3);
        hold(2'b01, 2);
        hold(2'b00, 8);
        check("partial_ticks",
              32'((n_in_seen - in0) + (n_out_seen - out0) + (n_err_seen - err0)), 32'd0);
        check("partial_count", 32'(bus.count), 32'd0);

        // reach count=2, stop inside IN3, reset asynchronously
        repeat (2) seq4(2'b10, 2'b11, 2'b01, 2'b00, 2);
        hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3);
        check("pre_rst_count", 32'(bus.count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_gate", 32'(bus.gate_open), 32'd0);
        model_reset();
        bus.sen_a = 1'b0;
        bus.sen_b = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        in0 = n_in_seen;
        hold(2'b00, 4);
        check("arst_no_in_tick", 32'(n_in_seen - in0), 32'd0);

        // random passages, back-outs, garbage and idle gaps
        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 5);
            h = $urandom_range(1, 3);
            case (kind)
                0: seq4(2'b10, 2'b11, 2'b01, 2'b00, h);
                1: seq4(2'b01, 2'b11, 2'b10, 2'b00, h);
                2: seq4(2'b10, 2'b11, 2'b10, 2'b00, h);
                3: seq4(2'b01, 2'b11, 2'b01, 2'b00, h);
                4: begin
                    repeat ($urandom_range(1, 5)) begin
                        r = 2'($urandom_range(0, 3));
                        hold(r, $urandom_range(1, 3));
                    end
                    hold(2'b00, 2);
                end
                default: hold(2'b00, $urandom_range(1, 8));
            endcase
        end
        hold(2'b00, 10);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
